// File: rtl/fp_bcd_converter_if.sv
// Handshake and result bundle between a fixed-point sample source and the BCD converter.
// The converter takes the slave side; the source/display side takes the master side.
interface fp_bcd_converter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  valid;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  ovf;

  modport master (output start, value, input busy, valid, bcd, neg, ovf);
  modport slave  (input start, value, output busy, valid, bcd, neg, ovf);
endinterface

// File: rtl/fp_bcd_converter.sv
// Rescales one signed fixed-point sample to a rounded decimal magnitude and converts it to
// packed BCD with an iterative double-dabble engine; sign and saturation are flagged apart.
module fp_bcd_converter #(
  parameter int WIDTH   = 32,
  parameter int FPSHIFT = 10,
  parameter int SCALE   = 1000,
  parameter int DIGITS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fp_bcd_converter_if.slave  bus
);
  localparam int BW     = 4 * DIGITS;
  localparam int MAG_W  = WIDTH + 1;
  localparam int PROD_W = WIDTH + 2 + $clog2(SCALE);
  localparam int CNT_W  = $clog2(BW + 1);

  localparam logic [MAG_W-1:0]  MAG_ONE = {{(MAG_W-1){1'b0}}, 1'b1};
  localparam logic [PROD_W-1:0] SCALE_C = PROD_W'(SCALE);
  localparam logic [PROD_W-1:0] ROUND_C = {{(PROD_W-1){1'b0}}, 1'b1} << (FPSHIFT - 1);
  localparam logic [PROD_W-1:0] MAX_C   = PROD_W'(10**DIGITS - 1);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(BW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCALE, S_CONVERT, S_DONE} state_t;

  state_t              state_r, state_s;
  logic [WIDTH-1:0]    value_r;
  logic [BW-1:0]       bin_r, acc_r, bcd_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                neg_pend_r, ovf_pend_r;
  logic                busy_r, valid_r, neg_r, ovf_r;

  logic [MAG_W-1:0]    ext_s, mag_s;
  logic [PROD_W-1:0]   prod_s, rnd_s;
  logic [BW-1:0]       res_s;
  logic                ovf_s;
  logic [2*BW-1:0]     shift_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] acc);
    logic [BW-1:0] res;
    res = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = acc[4*i +: 4];
      end
    end
    return res;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s = S_SCALE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SCALE:   state_s = S_CONVERT;
      S_CONVERT: begin
        if (cnt_r == LAST_C) begin
          state_s = S_DONE;
        end else begin
          state_s = S_CONVERT;
        end
      end
      S_DONE:    state_s = S_IDLE;
      default:   state_s = S_IDLE;
    endcase
  end

  // Magnitude is one bit wider than the input so the most-negative sample negates exactly.
  always_comb begin
    ext_s = {value_r[WIDTH-1], value_r};
    if (value_r[WIDTH-1]) begin
      mag_s = ~ext_s + MAG_ONE;
    end else begin
      mag_s = ext_s;
    end
    prod_s  = PROD_W'(mag_s) * SCALE_C + ROUND_C;
    rnd_s   = prod_s >> FPSHIFT;
    if (rnd_s > MAX_C) begin
      ovf_s = 1'b1;
      res_s = BW'(MAX_C);
    end else begin
      ovf_s = 1'b0;
      res_s = rnd_s[BW-1:0];
    end
    shift_s = {dabble_adjust(acc_r), bin_r};
  end

  // Datapath and registered outputs; results only move in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r    <= {WIDTH{1'b0}};
      bin_r      <= {BW{1'b0}};
      acc_r      <= {BW{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      neg_pend_r <= 1'b0;
      ovf_pend_r <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      bcd_r      <= {BW{1'b0}};
      neg_r      <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            value_r <= bus.value;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        S_SCALE: begin
          bin_r      <= res_s;
          acc_r      <= {BW{1'b0}};
          cnt_r      <= {CNT_W{1'b0}};
          neg_pend_r <= value_r[WIDTH-1] && (res_s != {BW{1'b0}});
          ovf_pend_r <= ovf_s;
        end
        S_CONVERT: begin
          {acc_r, bin_r} <= {shift_s[2*BW-2:0], 1'b0};
          cnt_r          <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        S_DONE: begin
          bcd_r   <= acc_r;
          neg_r   <= neg_pend_r;
          ovf_r   <= ovf_pend_r;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_r;
  assign bus.valid = valid_r;
  assign bus.bcd   = bcd_r;
  assign bus.neg   = neg_r;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_fp_bcd_converter.sv
// Scoreboard bench for fp_bcd_converter: expected results are queued when a start is issued
// and compared when valid pulses; latency, handshake and reset behaviour are checked as well.
module tb_fp_bcd_converter;
  typedef struct packed {
    logic [15:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];
  logic prev_valid;

  fp_bcd_converter_if #(.WIDTH(32), .DIGITS(4)) bus ();

  fp_bcd_converter #(.WIDTH(32), .FPSHIFT(10), .SCALE(1000), .DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic, BCD built by repeated division.
  function automatic exp_t model(input logic [31:0] v);
    exp_t   e;
    longint m, r, t;
    m = (v[31]) ? -longint'($signed(v)) : longint'($signed(v));
    r = (m * 1000 + 512) >>> 10;
    e.ovf = (r > 9999);
    if (r > 9999) r = 9999;
    e.neg = v[31] && (r != 0);
    t = r;
    for (int d = 0; d < 4; d++) begin
      e.bcd[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return e;
  endfunction

  // Pop and compare on every valid pulse.
  always @(negedge clk) begin
    if (bus.valid) begin
      if (prev_valid) check_val("valid_consecutive", 32'd1, 32'd0);
      check_val("busy_at_valid", {31'd0, bus.busy}, 32'd0);
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("bcd", {16'd0, bus.bcd}, {16'd0, e.bcd});
        check_val("neg", {31'd0, bus.neg}, {31'd0, e.neg});
        check_val("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
      end
    end
    prev_valid <= bus.valid;
  end

  // Called just before a rising edge: drives start so that this edge accepts it.
  task automatic issue(input logic [31:0] v);
    bus.start = 1'b1;
    bus.value = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.value = 32'h5a5a_1234;
    check_val("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  // Waits for valid, optionally re-pulsing start at cycles pa/pb; checks edges from acceptance.
  task automatic await_valid(input int pa, input int pb);
    int lat;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == pa || k == pb) begin
        bus.start = 1'b1;
        bus.value = 32'd5000;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.valid) begin
        lat = k - 1;
        break;
      end
    end
    bus.start = 1'b0;
    check_val("latency", lat, 32'd18);
  endtask

  task automatic run_conv(input logic [31:0] v, input exp_t e, input int pa, input int pb);
    @(negedge clk);
    sb.push_back(e);
    issue(v);
    await_valid(pa, pb);
  endtask

  typedef struct packed {
    logic [31:0] v;
    exp_t        e;
  } vec_t;

  vec_t    vecs[8];
  time     t_first;
  time     t_second;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    prev_valid = 1'b0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.value  = 32'd0;
    vecs[0] = '{32'd1024,       '{16'h1000, 1'b0, 1'b0}};
    vecs[1] = '{-32'sd512,      '{16'h0500, 1'b1, 1'b0}};
    vecs[2] = '{32'd724,        '{16'h0707, 1'b0, 1'b0}};
    vecs[3] = '{32'd1,          '{16'h0001, 1'b0, 1'b0}};
    vecs[4] = '{32'd0,          '{16'h0000, 1'b0, 1'b0}};
    vecs[5] = '{32'hffff_ffff,  '{16'h0001, 1'b1, 1'b0}};
    vecs[6] = '{32'd11264,      '{16'h9999, 1'b0, 1'b1}};
    vecs[7] = '{32'h8000_0000,  '{16'h9999, 1'b1, 1'b1}};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_busy",  {31'd0, bus.busy},  32'd0);
    check_val("rst_valid", {31'd0, bus.valid}, 32'd0);
    check_val("rst_bcd",   {16'd0, bus.bcd},   32'd0);
    check_val("rst_neg",   {31'd0, bus.neg},   32'd0);
    check_val("rst_ovf",   {31'd0, bus.ovf},   32'd0);

    foreach (vecs[i]) run_conv(vecs[i].v, vecs[i].e, 0, 0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] rv;
      rv = 32'($signed(int'($urandom_range(24000, 0)) - 12000));
      run_conv(rv, model(rv), 0, 0);
    end

    // Starts during a conversion are ignored: one result, from the first value.
    run_conv(32'd1024, '{16'h1000, 1'b0, 1'b0}, 3, 10);
    repeat (25) @(negedge clk);

    // Start coincident with valid is accepted; results 19 cycles apart.
    @(negedge clk);
    sb.push_back('{16'h0707, 1'b0, 1'b0});
    issue(32'd724);
    await_valid(0, 0);
    t_first = $time;
    sb.push_back('{16'h0500, 1'b1, 1'b0});
    issue(-32'sd512);
    await_valid(0, 0);
    t_second = $time;
    check_val("b2b_spacing", 32'((t_second - t_first) / 10), 32'd19);

    // Reset in the middle of a conversion aborts it and clears the outputs.
    @(negedge clk);
    issue(32'd11264);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("abort_busy",  {31'd0, bus.busy},  32'd0);
    check_val("abort_valid", {31'd0, bus.valid}, 32'd0);
    check_val("abort_bcd",   {16'd0, bus.bcd},   32'd0);
    check_val("abort_neg",   {31'd0, bus.neg},   32'd0);
    check_val("abort_ovf",   {31'd0, bus.ovf},   32'd0);
    repeat (30) @(negedge clk);

    run_conv(32'd724, '{16'h0707, 1'b0, 1'b0}, 0, 0);

    // Reset and start on the same edge: nothing starts.
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.value = 32'd1024;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check_val("rst_start_busy", {31'd0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    check_val("rst_start_idle", {31'd0, bus.busy}, 32'd0);
    repeat (25) @(negedge clk);

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
